// File: rtl/result_packer_if.sv
// rtl/result_packer_if.sv - push, line and status signal bundle for result_packer
interface result_packer_if #(
    parameter int FIFO_DEPTH = 64
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [15:0]   i_result_data;
    logic          i_result_valid;
    logic          o_result_full;
    logic          o_result_afull;
    logic          i_flush;
    logic [255:0]  o_line_data;
    logic          o_line_valid;
    logic          i_line_ready;
    logic [4:0]    o_line_lanes;
    logic          o_line_last;
    logic          o_flush_done;
    logic [CW-1:0] o_fifo_count;
    logic          o_overflow;
    logic [15:0]   o_drop_count;
    logic [15:0]   o_line_count;

    modport slave (
        input  i_result_data, i_result_valid, i_flush, i_line_ready,
        output o_result_full, o_result_afull, o_line_data, o_line_valid,
        output o_line_lanes, o_line_last, o_flush_done, o_fifo_count,
        output o_overflow, o_drop_count, o_line_count
    );

    modport master (
        output i_result_data, i_result_valid, i_flush, i_line_ready,
        input  o_result_full, o_result_afull, o_line_data, o_line_valid,
        input  o_line_lanes, o_line_last, o_flush_done, o_fifo_count,
        input  o_overflow, o_drop_count, o_line_count
    );
endinterface

// File: rtl/result_packer.sv
// rtl/result_packer.sv - FP16 result FIFO packing 16 lanes per 256-bit line
// Optional statistics counters: define RESULT_PACKER_STATS_EN.
module result_packer #(
    parameter int FIFO_DEPTH   = 64,
    parameter int AFULL_MARGIN = 4
) (
    input  logic           i_clk,
    input  logic           i_reset_n,
    result_packer_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] AFULL_C = CW'(FIFO_DEPTH - AFULL_MARGIN);

    typedef enum logic {ST_FILL, ST_OUT} state_t;

    state_t        state_q;
    logic [15:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [4:0]    lane_cnt_q;
    logic          flush_pending_q;
    logic [255:0]  line_q;
    logic          line_valid_q;
    logic [4:0]    line_lanes_q;
    logic          line_last_q;
    logic          flush_done_q;
    logic          overflow_q;

    logic          full;
    logic          push;
    logic          drop;
    logic          pop;
    logic          accept;
    logic [15:0]   pop_data;
    logic [7:0]    lane_base;

    assign full      = (count_q == DEPTH_C);
    assign push      = bus.i_result_valid && !full;
    assign drop      = bus.i_result_valid && full;
    assign pop       = (state_q == ST_FILL) && (count_q != '0);
    assign accept    = (state_q == ST_OUT) && bus.i_line_ready;
    assign pop_data  = mem_q[rd_ptr_q];
    assign lane_base = {lane_cnt_q[3:0], 4'b0000};

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.i_result_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q         <= ST_FILL;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            lane_cnt_q      <= '0;
            flush_pending_q <= 1'b0;
            line_q          <= '0;
            line_valid_q    <= 1'b0;
            line_lanes_q    <= '0;
            line_last_q     <= 1'b0;
            flush_done_q    <= 1'b0;
            overflow_q      <= 1'b0;
        end else begin
            flush_done_q <= 1'b0;
            // A flush arriving while one is pending simply merges; a later clear wins.
            if (bus.i_flush) begin
                flush_pending_q <= 1'b1;
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;

            case (state_q)
                ST_FILL: begin
                    if (pop) begin
                        line_q[lane_base +: 16] <= pop_data;
                        lane_cnt_q              <= lane_cnt_q + 5'd1;
                        if (lane_cnt_q == 5'd15) begin
                            state_q      <= ST_OUT;
                            line_valid_q <= 1'b1;
                            line_lanes_q <= 5'd16;
                            line_last_q  <= flush_pending_q && (count_d == '0);
                        end
                    end else if (flush_pending_q) begin
                        // No pop in ST_FILL means the FIFO is empty here.
                        if (lane_cnt_q != 5'd0) begin
                            state_q      <= ST_OUT;
                            line_valid_q <= 1'b1;
                            line_lanes_q <= lane_cnt_q;
                            line_last_q  <= 1'b1;
                        end else begin
                            flush_done_q    <= 1'b1;
                            flush_pending_q <= 1'b0;
                        end
                    end
                end
                ST_OUT: begin
                    if (accept) begin
                        state_q      <= ST_FILL;
                        line_valid_q <= 1'b0;
                        line_q       <= '0;
                        line_lanes_q <= '0;
                        line_last_q  <= 1'b0;
                        lane_cnt_q   <= '0;
                        if (line_last_q) begin
                            flush_done_q    <= 1'b1;
                            flush_pending_q <= 1'b0;
                        end
                    end
                end
                default: state_q <= ST_FILL;
            endcase
        end
    end

    assign bus.o_result_full  = full;
    assign bus.o_result_afull = (count_q >= AFULL_C);
    assign bus.o_line_data    = line_q;
    assign bus.o_line_valid   = line_valid_q;
    assign bus.o_line_lanes   = line_lanes_q;
    assign bus.o_line_last    = line_last_q;
    assign bus.o_flush_done   = flush_done_q;
    assign bus.o_fifo_count   = count_q;
    assign bus.o_overflow     = overflow_q;

`ifdef RESULT_PACKER_STATS_EN
    logic [15:0] drop_cnt_q;
    logic [15:0] line_cnt_q;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            drop_cnt_q <= '0;
            line_cnt_q <= '0;
        end else begin
            if (drop && (drop_cnt_q != 16'hFFFF)) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
            if (accept && (line_cnt_q != 16'hFFFF)) begin
                line_cnt_q <= line_cnt_q + 16'd1;
            end
        end
    end

    assign bus.o_drop_count = drop_cnt_q;
    assign bus.o_line_count = line_cnt_q;
`else
    assign bus.o_drop_count = '0;
    assign bus.o_line_count = '0;
`endif
endmodule

// File: tb/tb_result_packer.sv
// tb/tb_result_packer.sv - randomized self-checking bench for result_packer
module tb_result_packer;
    localparam int DEPTH = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    result_packer_if #(.FIFO_DEPTH(DEPTH)) bus();

    result_packer #(.FIFO_DEPTH(DEPTH), .AFULL_MARGIN(4)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    typedef struct {
        logic [255:0] data;
        logic [4:0]   lanes;
        logic         last;
    } line_t;

    line_t       got_q[$];
    line_t       exp_q[$];
    logic [15:0] pend_q[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          fd_cnt = 0;
    int          fd_cyc = -1;
    int          acc_last_cyc = -100;
    int          lines_acc = 0;
    bit          rand_ready = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: consecutive accepted results fill lanes in order, 16 per line; flush closes a partial line.
    function automatic void model_emit(input bit last);
        line_t l;
        l.data = '0;
        foreach (pend_q[i]) l.data[16*i +: 16] = pend_q[i];
        l.lanes = 5'(pend_q.size());
        l.last  = last;
        exp_q.push_back(l);
        pend_q.delete();
    endfunction

    function automatic void model_push(input logic [15:0] v);
        pend_q.push_back(v);
        if (pend_q.size() == 16) model_emit(1'b0);
    endfunction

    function automatic void model_flush();
        if (pend_q.size() > 0) model_emit(1'b1);
    endfunction

    line_t prev;
    bit    prev_hold = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check_val("hold_valid", 256'(bus.o_line_valid), 256'(1));
                check_val("hold_data", bus.o_line_data, prev.data);
                check_val("hold_lanes", 256'(bus.o_line_lanes), 256'(prev.lanes));
                check_val("hold_last", 256'(bus.o_line_last), 256'(prev.last));
            end
            if (bus.o_flush_done) begin
                fd_cnt++;
                fd_cyc = cyc;
            end
            if (bus.o_line_valid && bus.i_line_ready) begin
                got_q.push_back('{bus.o_line_data, bus.o_line_lanes, bus.o_line_last});
                lines_acc++;
                if (bus.o_line_last) acc_last_cyc = cyc;
            end
            prev_hold  = bus.o_line_valid && !bus.i_line_ready;
            prev.data  = bus.o_line_data;
            prev.lanes = bus.o_line_lanes;
            prev.last  = bus.o_line_last;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) bus.i_line_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic push(input logic [15:0] v);
        bus.i_result_valid = 1'b1;
        bus.i_result_data  = v;
        tick();
        bus.i_result_valid = 1'b0;
    endtask

    task automatic pulse_flush();
        bus.i_flush = 1'b1;
        tick();
        bus.i_flush = 1'b0;
    endtask

    task automatic wait_lines(input string tag, input int n, input int budget);
        int k = 0;
        while (got_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        check_val(tag, 256'(got_q.size() >= n), 256'(1));
    endtask

    task automatic wait_empty(input string tag, input int budget);
        int k = 0;
        while (bus.o_fifo_count != 0 && k < budget) begin
            tick();
            k++;
        end
        check_val(tag, 256'(bus.o_fifo_count), 256'(0));
    endtask

    task automatic wait_flush_done(input string tag, input int budget);
        int base = fd_cnt;
        int k = 0;
        while (fd_cnt == base && k < budget) begin
            tick();
            k++;
        end
        check_val(tag, 256'(fd_cnt - base), 256'(1));
    endtask

    task automatic compare_lines(input string tag);
        check_val({tag, "_nlines"}, 256'(got_q.size()), 256'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check_val($sformatf("%s_data%0d", tag, i), got_q[i].data, exp_q[i].data);
            check_val($sformatf("%s_lanes%0d", tag, i), 256'(got_q[i].lanes), 256'(exp_q[i].lanes));
            check_val($sformatf("%s_last%0d", tag, i), 256'(got_q[i].last), 256'(exp_q[i].last));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int exp_cnt;
        int fd_base;
        int lines_base;
        logic [15:0] v;

        bus.i_result_data  = '0;
        bus.i_result_valid = 1'b0;
        bus.i_flush        = 1'b0;
        bus.i_line_ready   = 1'b0;
        repeat (3) tick();

        check_val("rst_valid", 256'(bus.o_line_valid), 256'(0));
        check_val("rst_count", 256'(bus.o_fifo_count), 256'(0));
        check_val("rst_full", 256'(bus.o_result_full), 256'(0));
        check_val("rst_afull", 256'(bus.o_result_afull), 256'(0));
        check_val("rst_ovf", 256'(bus.o_overflow), 256'(0));
        check_val("rst_data", bus.o_line_data, 256'(0));
        check_val("rst_lanes", 256'(bus.o_line_lanes), 256'(0));
        check_val("rst_last", 256'(bus.o_line_last), 256'(0));
        check_val("rst_fdone", 256'(bus.o_flush_done), 256'(0));
        check_val("rst_drops", 256'(bus.o_drop_count), 256'(0));
        check_val("rst_lcount", 256'(bus.o_line_count), 256'(0));
        rst_n = 1'b1;
        tick();

        // Two full lines from a counting sequence
        bus.i_line_ready = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            push(16'(i));
            model_push(16'(i));
        end
        wait_lines("t1_wait", 2, 200);
        compare_lines("t1");

        // Five results then flush: partial last line, done pulse right after acceptance
        for (int i = 0; i < 5; i++) begin
            v = 16'h0100 + 16'(i);
            push(v);
            model_push(v);
        end
        wait_empty("t2_drain", 100);
        fd_base = fd_cnt;
        pulse_flush();
        model_flush();
        wait_lines("t2_wait", 1, 100);
        repeat (3) tick();
        compare_lines("t2");
        check_val("t2_fd_count", 256'(fd_cnt - fd_base), 256'(1));
        check_val("t2_fd_timing", 256'(fd_cyc), 256'(acc_last_cyc + 1));

        // Backpressure: one line captured, then 64 buffered, then three drops
        bus.i_line_ready = 1'b0;
        for (int i = 0; i < 80; i++) begin
            v = 16'($urandom);
            push(v);
            model_push(v);
            exp_cnt = i + 1 - ((i < 16) ? i : 16);
            check_val($sformatf("t3_count%0d", i), 256'(bus.o_fifo_count), 256'(exp_cnt));
            check_val($sformatf("t3_afull%0d", i), 256'(bus.o_result_afull), 256'(exp_cnt >= 60));
            check_val($sformatf("t3_full%0d", i), 256'(bus.o_result_full), 256'(exp_cnt == 64));
        end
        for (int i = 0; i < 3; i++) begin
            push(16'($urandom));
            check_val("t3_full_drop", 256'(bus.o_result_full), 256'(1));
        end
        check_val("t3_count_full", 256'(bus.o_fifo_count), 256'(64));
        check_val("t3_overflow", 256'(bus.o_overflow), 256'(1));
`ifdef RESULT_PACKER_STATS_EN
        check_val("t3_drops", 256'(bus.o_drop_count), 256'(3));
`else
        check_val("t3_drops", 256'(bus.o_drop_count), 256'(0));
`endif

        // Accept the held line, let one pop happen, then push and pop together at 63
        bus.i_line_ready = 1'b1;
        tick();
        bus.i_line_ready = 1'b0;
        check_val("t4_accepted", 256'(got_q.size()), 256'(1));
        tick();
        check_val("t4_count63", 256'(bus.o_fifo_count), 256'(63));
        v = 16'($urandom);
        push(v);
        model_push(v);
        check_val("t4_count_pp", 256'(bus.o_fifo_count), 256'(63));
        check_val("t4_full_pp", 256'(bus.o_result_full), 256'(0));
        bus.i_line_ready = 1'b1;
        wait_empty("t4_drain", 300);
        pulse_flush();
        model_flush();
        wait_flush_done("t4_fdone", 300);
        tick();
        compare_lines("t4");

        // Flush with nothing buffered
        fd_base = fd_cnt;
        pulse_flush();
        repeat (10) tick();
        check_val("t5_fd_once", 256'(fd_cnt - fd_base), 256'(1));
        check_val("t5_no_line", 256'(got_q.size()), 256'(0));

        // Reset while a full line is held
        bus.i_line_ready = 1'b0;
        for (int i = 0; i < 16; i++) push(16'($urandom));
        begin
            int k = 0;
            while (!bus.o_line_valid && k < 50) begin
                tick();
                k++;
            end
        end
        check_val("t6_held_valid", 256'(bus.o_line_valid), 256'(1));
        check_val("t6_held_lanes", 256'(bus.o_line_lanes), 256'(16));
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        lines_base = lines_acc;
        check_val("t6_valid", 256'(bus.o_line_valid), 256'(0));
        check_val("t6_count", 256'(bus.o_fifo_count), 256'(0));
        check_val("t6_ovf", 256'(bus.o_overflow), 256'(0));
        check_val("t6_drops", 256'(bus.o_drop_count), 256'(0));
        bus.i_line_ready = 1'b1;
        repeat (30) tick();
        check_val("t6_no_stale", 256'(got_q.size()), 256'(0));
        check_val("t6_valid_after", 256'(bus.o_line_valid), 256'(0));

        // Random rounds with random backpressure and idle gaps
        rand_ready = 1'b1;
        for (int r = 0; r < 6; r++) begin
            int n = int'($urandom_range(1, 40));
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0) tick();
                v = 16'($urandom);
                push(v);
                model_push(v);
            end
            wait_empty($sformatf("r%0d_drain", r), 500);
            pulse_flush();
            model_flush();
            wait_flush_done($sformatf("r%0d_fdone", r), 500);
            compare_lines($sformatf("r%0d", r));
        end
        rand_ready = 1'b0;
        bus.i_line_ready = 1'b1;
        tick();
`ifdef RESULT_PACKER_STATS_EN
        check_val("stats_lines", 256'(bus.o_line_count), 256'(lines_acc - lines_base));
`else
        check_val("stats_lines", 256'(bus.o_line_count), 256'(0));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/result_packer.md
RESULT_PACKER -- requirements
Module: result_packer

Interface
REQ-001 The module SHALL have parameter FIFO_DEPTH, default 64, setting the FP16 entry capacity of the input FIFO (power of two, 16..512).
REQ-002 The module SHALL have parameter AFULL_MARGIN, default 4, setting the free-entry threshold for almost-full.
REQ-003 The module SHALL have port i_clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 The module SHALL have port i_reset_n, input, 1, a synchronous active-low reset.
REQ-005 The module SHALL have port i_result_data, input, 16, the FP16 result from the compute engine.
REQ-006 The module SHALL have port i_result_valid, input, 1, the push strobe for i_result_data.
REQ-007 The module SHALL have port o_result_full, output, 1, asserted when the FIFO holds FIFO_DEPTH entries.
REQ-008 The module SHALL have port o_result_afull, output, 1, asserted when count >= FIFO_DEPTH-AFULL_MARGIN.
REQ-009 The module SHALL have port i_flush, input, 1, a tile-done pulse requesting emission of any partial line.
REQ-010 The module SHALL have port o_line_data, output, 256, holding 16 packed FP16 lanes, with lane k at bits [16k+15:16k].
REQ-011 The module SHALL have port o_line_valid, output, 1, and port i_line_ready, input, 1, forming a valid/ready line handshake.
REQ-012 The module SHALL have port o_line_lanes, output, 5, giving the number of valid lanes (1..16) in o_line_data.
REQ-013 The module SHALL have port o_line_last, output, 1, marking the final line of a flush.
REQ-014 The module SHALL have port o_flush_done, output, 1, a one-cycle pulse when a flush completes.
REQ-015 The module SHALL have port o_fifo_count, output, $clog2(FIFO_DEPTH)+1, giving the registered FIFO occupancy.
REQ-016 The module SHALL have port o_overflow, output, 1, a sticky flag set when a push is attempted while full.
REQ-017 The module SHALL have port o_drop_count, output, 16, and port o_line_count, output, 16, as statistics counters (see Configuration).

Function
REQ-018 A push SHALL occur when i_result_valid=1 and o_result_full=0; a push while full SHALL be discarded and SHALL set o_overflow.
REQ-019 A pushed entry SHALL be visible in o_fifo_count on the next cycle and SHALL be poppable no earlier than that cycle.
REQ-020 A simultaneous push and pop SHALL leave the count unchanged; the pointers SHALL wrap modulo FIFO_DEPTH.
REQ-021 The state machine SHALL have two states, ST_FILL and ST_OUT, and SHALL reset to ST_FILL.
REQ-022 In ST_FILL, the module SHALL pop one entry per cycle while the FIFO is non-empty, writing it to lane lane_cnt and incrementing lane_cnt.
REQ-023 On the 16th lane, the module SHALL go to ST_OUT with o_line_lanes=16.
REQ-024 i_flush SHALL set flush_pending; a pulse that arrives while a flush is pending SHALL be merged into it.
REQ-025 In ST_FILL, when flush_pending=1, the FIFO is empty and 0<lane_cnt<16, the module SHALL go to ST_OUT with unused lanes zero and o_line_lanes=lane_cnt.
REQ-026 o_line_last SHALL be 1 on any line entering ST_OUT while flush_pending=1 and the FIFO is empty.
REQ-027 In ST_OUT, o_line_valid=1 and o_line_data, o_line_lanes and o_line_last SHALL hold stable until i_line_ready=1.
REQ-028 On acceptance, the module SHALL clear lane_cnt and return to ST_FILL; if o_line_last was 1, it SHALL also clear flush_pending and pulse o_flush_done on the following cycle.
REQ-029 If flush_pending=1, the FIFO is empty and lane_cnt=0 in ST_FILL, the module SHALL pulse o_flush_done the next cycle without emitting a line, and SHALL clear flush_pending.
REQ-030 No pops SHALL occur in ST_OUT; pushes SHALL continue there.
REQ-031 o_line_valid SHALL never depend combinationally on i_line_ready.

Reset
REQ-032 While i_reset_n=0 at a clock edge, all of the following SHALL be cleared to 0: pointers, count, lane_cnt, flush_pending, o_line_valid, o_line_data, o_line_lanes, o_line_last, o_flush_done, o_overflow, and the counters; the state SHALL be ST_FILL.
REQ-033 Reset mid-line SHALL discard all buffered data; no line SHALL be emitted for it.

Configuration
REQ-034 With RESULT_PACKER_STATS_EN defined, o_drop_count SHALL increment (saturating at 0xFFFF) on each discarded push, and o_line_count SHALL increment (saturating) on each accepted line.
REQ-035 Without RESULT_PACKER_STATS_EN, o_drop_count and o_line_count SHALL be constant 0 and no counter logic SHALL be synthesized; o_overflow SHALL remain functional.

Verification
REQ-036 The bench SHALL push 32 results 0x0001..0x0020 with i_line_ready=1 and check two lines, with lane0 of line1 = 0x0001, lane15 of line2 = 0x0020, lanes=16 and last=0.
REQ-037 The bench SHALL push 5 results then pulse i_flush, and check one line with lanes=5, lanes 5..15 = 0, last=1, and o_flush_done pulsing the cycle after acceptance.
REQ-038 The bench SHALL hold i_line_ready=0, push until full, then push 3 more, and check full=1, afull asserted at count 60, overflow=1, and drop_count=3 when STATS_EN is defined (0 when not).
REQ-039 The bench SHALL pulse i_flush with nothing buffered and check no line is emitted and o_flush_done pulses once.
REQ-040 The bench SHALL pulse i_reset_n low for one cycle while in ST_OUT with 16 lanes held, and check o_line_valid=0 and o_fifo_count=0 the next cycle, with no stale line afterwards.
REQ-041 The bench SHALL apply a simultaneous push and pop at count 63 and check the count stays 63 and full stays 0.
